// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing a multi-cycle MIPS-style datapath.
module multicycle_control #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic [3:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
    MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, I_EXEC = 4'd8, I_WB = 4'd9,
    BRANCH = 4'd10, JUMP = 4'd11, JAL = 4'd12, TRAP = 4'd13
  } state_t;

  state_t cur, nxt;
  logic [3:0] aop;
  logic retire;

  assign state  = cur;
  assign alu_op = ALUOP_W'(aop);
  assign retire = (nxt == FETCH) &&
                  (cur inside {MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JAL});

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  // Sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      illegal <= illegal | (nxt == TRAP);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Next-state logic; memory-access states wait for mem_ready
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE:
        case (opcode)
          6'd0:                           nxt = R_EXEC;
          6'd8, 6'd12, 6'd13, 6'd14, 6'd10: nxt = I_EXEC;
          6'd35, 6'd43:                   nxt = MEM_ADDR;
          6'd4, 6'd5:                     nxt = BRANCH;
          6'd2:                           nxt = JUMP;
          6'd3:                           nxt = JAL;
          default:                        nxt = TRAP;
        endcase
      MEM_ADDR: nxt = (opcode == 6'd35) ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   nxt = mem_ready ? FETCH : MEM_WR;
      R_EXEC:   nxt = R_WB;
      I_EXEC:   nxt = I_WB;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

  // Control outputs per state, all forced low while reset is asserted
  always_comb begin
    {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
     reg_write, alu_src_a, alu_src_b, aop, pc_src} = '0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE:   alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        aop       = 4'd2;
      end
      R_WB: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aop = (opcode == 6'd12) ? 4'd3 :
              (opcode == 6'd13) ? 4'd4 :
              (opcode == 6'd14) ? 4'd5 :
              (opcode == 6'd10) ? 4'd6 : 4'd0;
      end
      I_WB:     reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 1'b1;
        aop       = 4'd1;
        pc_src    = 2'b01;
        pc_write  = (opcode == 6'd4) ? zero : ~zero;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      JAL: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n)
      {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
       reg_write, alu_src_a, alu_src_b, aop, pc_src} = '0;
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: self-checking bench for multicycle_control.
module tb_multicycle_control;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a, illegal;
  logic [1:0] mem_to_reg, reg_dst, alu_src_b, pc_src;
  logic [3:0] alu_op, state;
  logic [15:0] retired;
  logic pc_write_b, ir_write_b, i_or_d_b, mem_read_b, mem_write_b, reg_write_b, alu_src_a_b, illegal_b;
  logic [1:0] mem_to_reg_b, reg_dst_b, alu_src_b_b, pc_src_b;
  logic [4:0] alu_op_b;
  logic [3:0] state_b, retired_b;
  logic [18:0] ctl;

  int cmp = 0, err = 0, ret_exp = 0;

  typedef int q_t[$];
  typedef struct {
    logic [5:0] op;
    logic       z;
    int         lat;
    int         st2;
    int         aop2;
    logic       pcw2;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  assign ctl = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .illegal(illegal), .retired(retired)
  );

  multicycle_control #(.ALUOP_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .ir_write(ir_write_b), .i_or_d(i_or_d_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b), .pc_src(pc_src_b),
    .state(state_b), .illegal(illegal_b), .retired(retired_b)
  );

  // Expected control vector for a state, taken straight from the per-state output table
  function automatic logic [18:0] exp_ctl(input int st, input logic [5:0] op, input logic z, input logic mr);
    logic pcw, irw, iod, mrd, mwr, rw, asa;
    logic [1:0] m2r, rd, asb, psrc;
    logic [3:0] aop;
    {pcw, irw, iod, mrd, mwr, rw, asa, m2r, rd, asb, psrc, aop} = '0;
    case (st)
      0:  begin mrd = 1; asb = 2'd1; pcw = mr; irw = mr; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin iod = 1; mrd = 1; end
      4:  begin m2r = 2'd1; rw = 1; end
      5:  begin iod = 1; mwr = 1; end
      6:  begin asa = 1; aop = 4'd2; end
      7:  begin rd = 2'd1; rw = 1; end
      8:  begin
            asa = 1; asb = 2'd2;
            aop = op == 6'd12 ? 4'd3 : op == 6'd13 ? 4'd4 : op == 6'd14 ? 4'd5 : op == 6'd10 ? 4'd6 : 4'd0;
          end
      9:  rw = 1;
      10: begin asa = 1; aop = 4'd1; psrc = 2'd1; pcw = (op == 6'd4) ? z : !z; end
      11: begin psrc = 2'd2; pcw = 1; end
      12: begin psrc = 2'd2; pcw = 1; rd = 2'd2; m2r = 2'd2; rw = 1; end
      default: ;
    endcase
    return {pcw, irw, iod, mrd, mwr, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  // Sequence of states an instruction visits, ignoring memory wait cycles
  function automatic q_t path(input logic [5:0] op);
    q_t r;
    case (op)
      6'd0:       r = {0, 1, 6, 7};
      6'd35:      r = {0, 1, 2, 3, 4};
      6'd43:      r = {0, 1, 2, 5};
      6'd4, 6'd5: r = {0, 1, 10};
      6'd2:       r = {0, 1, 11};
      6'd3:       r = {0, 1, 12};
      default:    r = {0, 1, 8, 9};
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic z, input logic mr);
    @(negedge clk);
    opcode = op;
    zero = z;
    mem_ready = mr;
    #1;
  endtask

  task automatic step(input logic [5:0] op, input logic z, input logic mr, input int st, input string nm);
    drive(op, z, mr);
    chk({nm, "_state"}, 32'(state), 32'(st));
    chk({nm, "_ctl"}, 32'(ctl), 32'(exp_ctl(st, op, z, mr)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst_ctl_zero", 32'(ctl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'd0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_ctl_fetch", 32'(ctl), 32'(exp_ctl(0, 6'd0, 1'b0, 1'b0)));
    ret_exp = 0;
  endtask

  initial begin
    int lat;
    int q[$];
    logic [5:0] op;
    logic z, mr;
    logic [5:0] ops[12];
    ops = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd14, 6'd10, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};
    tbl[0]  = '{6'd0,  1'b0, 4, 6,  2, 1'b0};
    tbl[1]  = '{6'd35, 1'b0, 5, 2,  0, 1'b0};
    tbl[2]  = '{6'd43, 1'b0, 4, 2,  0, 1'b0};
    tbl[3]  = '{6'd4,  1'b1, 3, 10, 1, 1'b1};
    tbl[4]  = '{6'd4,  1'b0, 3, 10, 1, 1'b0};
    tbl[5]  = '{6'd5,  1'b1, 3, 10, 1, 1'b0};
    tbl[6]  = '{6'd5,  1'b0, 3, 10, 1, 1'b1};
    tbl[7]  = '{6'd2,  1'b0, 3, 11, 0, 1'b1};
    tbl[8]  = '{6'd3,  1'b0, 3, 12, 0, 1'b1};
    tbl[9]  = '{6'd8,  1'b0, 4, 8,  0, 1'b0};
    tbl[10] = '{6'd12, 1'b0, 4, 8,  3, 1'b0};
    tbl[11] = '{6'd13, 1'b0, 4, 8,  4, 1'b0};
    tbl[12] = '{6'd14, 1'b0, 4, 8,  5, 1'b0};
    tbl[13] = '{6'd10, 1'b0, 4, 8,  6, 1'b0};

    // 17 addi instructions: 4-bit counter instance wraps to 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(6'd8, 1'b0, 1'b1, 0, "addi_f");
      step(6'd8, 1'b0, 1'b1, 1, "addi_d");
      step(6'd8, 1'b0, 1'b1, 8, "addi_x");
      chk("addi_alu_op", 32'(alu_op), 32'd0);
      chk("addi_alu_src_b", 32'(alu_src_b), 32'd2);
      step(6'd8, 1'b0, 1'b1, 9, "addi_wb");
      ret_exp++;
    end
    step(6'd8, 1'b0, 1'b0, 0, "addi_end");
    chk("addi_retired", 32'(retired), 32'd17);
    chk("addi_wrap", 32'(retired_b), 32'd1);

    // R-type: states 0,1,6,7,0
    do_reset();
    step(6'd0, 1'b0, 1'b1, 0, "r_f");
    step(6'd0, 1'b0, 1'b1, 1, "r_d");
    step(6'd0, 1'b0, 1'b1, 6, "r_x");
    step(6'd0, 1'b0, 1'b1, 7, "r_wb");
    chk("r_reg_dst", 32'(reg_dst), 32'd1);
    chk("r_reg_write", 32'(reg_write), 32'd1);
    step(6'd0, 1'b0, 1'b0, 0, "r_end");
    chk("r_retired", 32'(retired), 32'd1);

    // lw with three wait cycles in MEM_RD
    step(6'd35, 1'b0, 1'b1, 0, "lw_f");
    step(6'd35, 1'b0, 1'b1, 1, "lw_d");
    step(6'd35, 1'b0, 1'b1, 2, "lw_a");
    for (int i = 0; i < 3; i++) begin
      step(6'd35, 1'b0, 1'b0, 3, "lw_wait");
      chk("lw_mem_read", 32'(mem_read), 32'd1);
      chk("lw_i_or_d", 32'(i_or_d), 32'd1);
    end
    step(6'd35, 1'b0, 1'b1, 3, "lw_rd");
    step(6'd35, 1'b0, 1'b1, 4, "lw_wb");
    chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
    step(6'd35, 1'b0, 1'b0, 0, "lw_end");
    chk("lw_retired", 32'(retired), 32'd2);

    // Unsupported opcode: TRAP until reset
    step(6'd63, 1'b0, 1'b1, 0, "trap_f");
    step(6'd63, 1'b0, 1'b1, 1, "trap_d");
    for (int i = 0; i < 20; i++) begin
      step(6'd63, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 13, "trap");
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_retired", 32'(retired), 32'd2);
    end
    do_reset();

    // Table of single instructions with mem_ready held high
    step(6'd0, 1'b0, 1'b1, 0, "tbl_start");
    for (int r = 0; r < 14; r++) begin
      lat = 0;
      for (int c = 1; c < 20; c++) begin
        drive(tbl[r].op, tbl[r].z, 1'b1);
        if (c == 2) begin
          chk("tbl_state2", 32'(state), 32'(tbl[r].st2));
          chk("tbl_alu_op2", 32'(alu_op), 32'(tbl[r].aop2));
          chk("tbl_pc_write2", 32'(pc_write), 32'(tbl[r].pcw2));
        end
        if (state == 4'd0) begin
          lat = c;
          break;
        end
      end
      chk("tbl_latency", 32'(lat), 32'(tbl[r].lat));
      ret_exp++;
      chk("tbl_retired", 32'(retired), 32'(ret_exp));
    end

    // Random instruction stream with random memory stalls against a path-queue model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (q.size() == 0) begin
        op = ops[$urandom_range(0, 11)];
        q = path(op);
      end
      z = 1'($urandom_range(0, 1));
      mr = ($urandom_range(0, 3) != 0);
      step(op, z, mr, q[0], "rnd");
      chk("rnd_retired", 32'(retired), 32'(ret_exp));
      chk("rnd_retired_b", 32'(retired_b), 32'(ret_exp % 16));
      chk("rnd_alu_op_hi", 32'(alu_op_b[4]), 32'd0);
      chk("rnd_illegal", 32'(illegal), 32'd0);
      if (!(!mr && (q[0] == 0 || q[0] == 3 || q[0] == 5))) begin
        void'(q.pop_front());
        if (q.size() == 0) ret_exp++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ALUOP_W, default 4, giving alu_op width; legal values are 4 or more, and bits above [3] SHALL be driven 0.
REQ-002 SHALL have parameter CNT_W, default 16, giving retired-instruction counter width.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 Ports, in order:
  clk  in  1  rising-edge clock
  rst_n  in  1  synchronous active-low reset
  opcode  in  6  IR[31:26], valid from DECODE onward
  zero  in  1  ALU zero flag
  mem_ready  in  1  memory completes access this cycle
  pc_write  out  1  PC load enable
  ir_write  out  1  IR load enable
  i_or_d  out  1  memory address: 0=PC, 1=ALUOut
  mem_read  out  1  memory read request
  mem_write  out  1  memory write request
  mem_to_reg  out  2  write-back source: 00=ALUOut, 01=MDR, 10=PC
  reg_dst  out  2  destination register: 00=rt, 01=rd, 10=$31
  reg_write  out  1  register file write enable
  alu_src_a  out  1  ALU A input: 0=PC, 1=rs
  alu_src_b  out  2  ALU B input: 00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2
  alu_op  out  ALUOP_W  ALU operation
  pc_src  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
  state  out  4  current state code
  illegal  out  1  sticky unsupported-opcode flag
  retired  out  CNT_W  retired-instruction count

Function
REQ-005 States and codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, JAL=12, TRAP=13; codes 14 and 15 are unreachable and SHALL go to FETCH.
REQ-006 alu_op encoding: 0=add, 1=sub, 2=use funct, 3=and, 4=or, 5=xor, 6=slt.
REQ-007 Any output not listed for a state SHALL be 0.
REQ-008 FETCH outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00; ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1.
REQ-009 FETCH SHALL hold while mem_ready=0 and go to DECODE on mem_ready=1.
REQ-010 DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=add (branch target precompute).
REQ-011 DECODE transitions by opcode:
  0 -> R_EXEC
  8/12/13/14/10 -> I_EXEC
  35/43 -> MEM_ADDR
  4/5 -> BRANCH
  2 -> JUMP
  3 -> JAL
  any other -> TRAP
REQ-012 MEM_ADDR outputs: alu_src_a=1, alu_src_b=10, alu_op=add; next state is MEM_RD when opcode=35, else MEM_WR.
REQ-013 MEM_RD and MEM_WR: i_or_d=1, plus mem_read=1 or mem_write=1 respectively; each SHALL hold until mem_ready=1; MEM_RD then goes to MEM_WB, MEM_WR then goes to FETCH.
REQ-014 MEM_WB outputs: reg_dst=00, mem_to_reg=01, reg_write=1; next state FETCH.
REQ-015 R_EXEC outputs: alu_src_a=1, alu_src_b=00, alu_op=funct; then R_WB.
REQ-016 R_WB outputs: reg_dst=01, mem_to_reg=00, reg_write=1; then FETCH.
REQ-017 I_EXEC outputs: alu_src_a=1, alu_src_b=10; alu_op = add/and/or/xor/slt for opcode 8/12/13/14/10; then I_WB.
REQ-018 I_WB outputs: reg_dst=00, mem_to_reg=00, reg_write=1; then FETCH.
REQ-019 BRANCH outputs: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01; pc_write = zero for opcode 4 and ~zero for opcode 5; then FETCH.
REQ-020 JUMP outputs: pc_src=10, pc_write=1; then FETCH.
REQ-021 JAL outputs: pc_src=10, pc_write=1, reg_dst=10, mem_to_reg=10, reg_write=1; then FETCH.
REQ-022 TRAP SHALL set illegal=1 on entry, assert no enables, and stay in TRAP until reset.
REQ-023 retired SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP or JAL, and SHALL wrap modulo 2^CNT_W.
REQ-024 Latency with mem_ready held 1: R/I-type 4 cycles, lw 5, sw 4, beq/bne/j/jal 3.
REQ-025 pc_write, ir_write, mem_read, mem_write and reg_write SHALL never be asserted in the same cycle as rst_n=0.

Reset
REQ-026 On a clk edge with rst_n=0: state SHALL become FETCH, illegal=0, retired=0.
REQ-027 While rst_n=0, all control outputs SHALL be forced to 0.
REQ-028 A reset during any state, including during a mem_ready wait or TRAP, SHALL abort the instruction with no further write enables.

Verification
REQ-029 Release reset, mem_ready=1, opcode=0 -> states 0,1,6,7,0; reg_write=1 with reg_dst=01 in R_WB; retired=1.
REQ-030 opcode=35 with mem_ready=0 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1, i_or_d=1; then MEM_WB with mem_to_reg=01.
REQ-031 opcode=4 with zero=1, then opcode=5 with zero=1 -> pc_write=1 in BRANCH the first time and 0 the second; pc_src=01 in both.
REQ-032 opcode=3 -> JAL with reg_dst=10, mem_to_reg=10, reg_write=1, pc_write=1, pc_src=10; retired increments.
REQ-033 opcode=63 -> TRAP, illegal=1, no enables for 20 cycles; then rst_n=0 for one edge -> state=0, illegal=0, retired=0.
REQ-034 With CNT_W=4, run 17 addi instructions -> retired wraps to 1; alu_op=0 and alu_src_b=10 in I_EXEC.
